// File: rtl/dshot_output_if.sv
// dshot_output_if: request channel into the DShot transmitter (valid/ready plus frame payload).
interface dshot_output_if;
    logic        sendValid;
    logic        sendReady;
    logic [10:0] sendThrottle;
    logic        sendTelemetry;
    modport master (output sendValid, sendThrottle, sendTelemetry, input sendReady);
    modport slave  (input sendValid, sendThrottle, sendTelemetry, output sendReady);
endinterface

// File: rtl/dshot_output.sv
// dshot_output: DShot frame serializer with valid/ready request port and optional auto-repeat.
// Define DSHOT_BIDIR_EN for bidirectional DShot (inverted line levels, inverted CRC).
module dshot_output #(
    parameter int BIT_CLKS = 80,
    parameter int T1H_CLKS = 60,
    parameter int T0H_CLKS = 30,
    parameter int GAP_CLKS = 40
) (
    input  logic          clk,
    input  logic          resetN,
    dshot_output_if.slave send,
    input  logic          autoRepeat,
    output logic          outPin,
    output logic          busy,
    output logic          frameDone
);
    localparam int MAXC = (BIT_CLKS > GAP_CLKS) ? BIT_CLKS : GAP_CLKS;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] T1_LAST = CW'(T1H_CLKS - 1);
    localparam logic [CW-1:0] T0_LAST = CW'(T0H_CLKS - 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CLKS - 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_LOW = 2'd2;
    localparam logic [1:0] S_GAP = 2'd3;
`ifdef DSHOT_BIDIR_EN
    localparam logic ACT_LVL = 1'b0;
    localparam logic [3:0] CRC_INV = 4'hF;
`else
    localparam logic ACT_LVL = 1'b1;
    localparam logic [3:0] CRC_INV = 4'h0;
`endif
    localparam logic IDLE_LVL = ~ACT_LVL;

    if (!(T0H_CLKS > 0 && T0H_CLKS < T1H_CLKS && T1H_CLKS < BIT_CLKS && GAP_CLKS >= 1)) begin : g_bad_params
        $error("dshot_output: illegal timing parameters");
    end

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [15:0]   shift_q, shift_d;
    logic [15:0]   frame_q, frame_d;
    logic          has_q, has_d;
    logic          out_q, out_d;
    logic [11:0]   value12;
    logic [15:0]   new_frame;

    assign value12 = {send.sendThrottle, send.sendTelemetry};
    assign new_frame = {value12, value12[3:0] ^ value12[7:4] ^ value12[11:8] ^ CRC_INV};
    assign send.sendReady = state_q == S_IDLE;
    assign busy = state_q != S_IDLE;
    assign frameDone = state_q == S_GAP && cnt_q == GAP_LAST;
    assign outPin = out_q;

    // A new request always wins over replaying the stored frame.
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q + 1'b1;
        bit_d = bit_q;
        shift_d = shift_q;
        frame_d = frame_q;
        has_d = has_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (send.sendValid) begin
                    state_d = S_HIGH;
                    shift_d = new_frame;
                    frame_d = new_frame;
                    has_d = 1'b1;
                end else if (autoRepeat && has_q) begin
                    state_d = S_HIGH;
                    shift_d = frame_q;
                end
            end
            S_HIGH: state_d = cnt_q == (shift_q[15] ? T1_LAST : T0_LAST) ? S_LOW : S_HIGH;
            S_LOW: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    state_d = bit_q == 4'd15 ? S_GAP : S_HIGH;
                    bit_d = bit_q + 4'd1;
                    shift_d = {shift_q[14:0], 1'b0};
                end
            end
            default: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    state_d = S_IDLE;
                end
            end
        endcase
        out_d = state_d == S_HIGH ? ACT_LVL : IDLE_LVL;
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q <= S_IDLE;
            cnt_q <= '0;
            bit_q <= '0;
            shift_q <= '0;
            frame_q <= '0;
            has_q <= 1'b0;
            out_q <= IDLE_LVL;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            bit_q <= bit_d;
            shift_q <= shift_d;
            frame_q <= frame_d;
            has_q <= has_d;
            out_q <= out_d;
        end
    end
endmodule

// File: tb/tb_dshot_output.sv
// tb_dshot_output: randomized self-checking bench; expected waveforms come from a per-cycle frame model.
module tb_dshot_output;
    localparam int BIT_T = 80;
    localparam int T1H = 60;
    localparam int T0H = 30;
    localparam int GAP_T = 40;
    localparam int FRAME_T = 16 * BIT_T + GAP_T + 1;
`ifdef DSHOT_BIDIR_EN
    localparam logic ACT = 1'b0;
    localparam logic [3:0] CRCX = 4'hF;
    localparam logic [15:0] EXP_1046 = 16'h82C9;
    localparam logic [15:0] EXP_0_1 = 16'h001E;
    localparam logic [15:0] EXP_2047_1 = 16'hFFF0;
`else
    localparam logic ACT = 1'b1;
    localparam logic [3:0] CRCX = 4'h0;
    localparam logic [15:0] EXP_1046 = 16'h82C6;
    localparam logic [15:0] EXP_0_1 = 16'h0011;
    localparam logic [15:0] EXP_2047_1 = 16'hFFFF;
`endif

    logic clk = 1'b0;
    logic resetN;
    logic autoRepeat, outPin, busy, frameDone;
    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int acc_cyc;
    logic w_lvl[FRAME_T], w_done[FRAME_T], w_busy[FRAME_T], w_rdy[FRAME_T];
    logic w_ok;
    int w_start;

    dshot_output_if bus ();

    dshot_output #(.BIT_CLKS(BIT_T), .T1H_CLKS(T1H), .T0H_CLKS(T0H), .GAP_CLKS(GAP_T)) dut (
        .clk(clk), .resetN(resetN), .send(bus), .autoRepeat(autoRepeat),
        .outPin(outPin), .busy(busy), .frameDone(frameDone)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] model_frame(input int thr, input logic tel);
        logic [11:0] v;
        logic [3:0] c;
        v = {thr[10:0], tel};
        c = v[3:0] ^ v[7:4] ^ v[11:8];
        return {v, c ^ CRCX};
    endfunction

    // Expected {outPin, frameDone, busy, sendReady} k cycles after the first active cycle.
    function automatic logic [3:0] model_at(input logic [15:0] f, input int k);
        logic act;
        act = k < 16 * BIT_T && (k % BIT_T) < (f[15 - k / BIT_T] ? T1H : T0H);
        return {act ? ACT : ~ACT, k == 16 * BIT_T + GAP_T - 1, k < FRAME_T - 1, k >= FRAME_T - 1};
    endfunction

    function automatic int first_dev(input logic [15:0] f);
        for (int k = 0; k < FRAME_T; k++)
            if ({w_lvl[k], w_done[k], w_busy[k], w_rdy[k]} !== model_at(f, k)) return k;
        return -1;
    endfunction

    function automatic logic [15:0] decode();
        logic [15:0] f;
        int h;
        for (int b = 0; b < 16; b++) begin
            h = 0;
            for (int i = 0; i < BIT_T; i++) if (w_lvl[b * BIT_T + i] === ACT) h++;
            f[15 - b] = 2 * h > T1H + T0H;
        end
        return f;
    endfunction

    function automatic int run_len(input int s, input logic lv);
        int n;
        n = 0;
        while (s + n < FRAME_T && w_lvl[s + n] === lv) n++;
        return n;
    endfunction

    task automatic send(input int thr, input logic tel);
        int n;
        bus.sendThrottle = thr[10:0];
        bus.sendTelemetry = tel;
        bus.sendValid = 1'b1;
        n = 0;
        while (bus.sendReady !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        acc_cyc = cyc;
        @(negedge clk);
        bus.sendValid = 1'b0;
    endtask

    task automatic capture(input int bound);
        int n;
        n = 0;
        while (outPin !== ACT && n < bound) begin
            @(negedge clk);
            n++;
        end
        w_ok = outPin === ACT;
        w_start = cyc;
        if (w_ok) begin
            for (int k = 0; k < FRAME_T; k++) begin
                if (k != 0) @(negedge clk);
                w_lvl[k] = outPin;
                w_done[k] = frameDone;
                w_busy[k] = busy;
                w_rdy[k] = bus.sendReady;
            end
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (outPin !== ~ACT) begin miscompares++; $display("FAIL reset_outPin got %b expected %b", outPin, ~ACT); end
        vectors++; if (bus.sendReady !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b expected 1", bus.sendReady); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b expected 0", busy); end
        vectors++; if (frameDone !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b expected 0", frameDone); end
        resetN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int dev, h0, l0, h1, l1, di;
        send(1046, 1'b0);
        capture(10);
        vectors++; if (w_ok !== 1'b1) begin miscompares++; $display("FAIL single_start got none expected frame"); end
        vectors++; if (w_start !== acc_cyc + 1) begin miscompares++; $display("FAIL single_latency got %0d expected %0d", w_start, acc_cyc + 1); end
        vectors++; if (decode() !== EXP_1046) begin miscompares++; $display("FAIL single_frame got %h expected %h", decode(), EXP_1046); end
        dev = first_dev(model_frame(1046, 1'b0));
        vectors++; if (dev !== -1) begin miscompares++; $display("FAIL single_wave got deviation at %0d expected none", dev); end
        h0 = run_len(0, ACT);
        l0 = run_len(h0, ~ACT);
        h1 = run_len(BIT_T, ACT);
        l1 = run_len(BIT_T + h1, ~ACT);
        vectors++; if (h0 !== T1H || l0 !== BIT_T - T1H) begin miscompares++; $display("FAIL bit0_width got %0d/%0d expected %0d/%0d", h0, l0, T1H, BIT_T - T1H); end
        vectors++; if (h1 !== T0H || l1 !== BIT_T - T0H) begin miscompares++; $display("FAIL bit1_width got %0d/%0d expected %0d/%0d", h1, l1, T0H, BIT_T - T0H); end
        di = -1;
        for (int k = FRAME_T - 1; k >= 0; k--) if (w_done[k] === 1'b1) di = k;
        vectors++; if (di !== 16 * BIT_T + GAP_T - 1) begin miscompares++; $display("FAIL single_done_idx got %0d expected %0d", di, 16 * BIT_T + GAP_T - 1); end
    endtask

    task automatic test_patterns();
        int thr[6];
        logic tel[6];
        logic [15:0] f;
        int dev;
        thr[0] = 0; tel[0] = 1'b1;
        thr[1] = 2047; tel[1] = 1'b1;
        for (int i = 2; i < 6; i++) begin
            thr[i] = $urandom_range(0, 2047);
            tel[i] = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 6; i++) begin
            send(thr[i], tel[i]);
            capture(10);
            f = model_frame(thr[i], tel[i]);
            vectors++; if (w_ok !== 1'b1 || decode() !== f) begin miscompares++; $display("FAIL pattern_frame thr=%0d got %h expected %h", thr[i], decode(), f); end
            dev = first_dev(f);
            vectors++; if (dev !== -1) begin miscompares++; $display("FAIL pattern_wave thr=%0d got deviation at %0d expected none", thr[i], dev); end
        end
        vectors++; if (model_frame(thr[0], tel[0]) !== EXP_0_1) begin miscompares++; $display("FAIL model_0 got %h expected %h", model_frame(0, 1'b1), EXP_0_1); end
        send(2047, 1'b1);
        capture(10);
        vectors++; if (decode() !== EXP_2047_1) begin miscompares++; $display("FAIL frame_2047 got %h expected %h", decode(), EXP_2047_1); end
        vectors++; if (run_len(15 * BIT_T, ACT) !== T1H) begin miscompares++; $display("FAIL frame_2047_bit15 got %0d expected %0d", run_len(15 * BIT_T, ACT), T1H); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] q[$];
        logic [15:0] exp_f;
        bit stop, flip;
        int cur, prev, n, dev;
        logic tel;
        tel = 1'($urandom_range(0, 1));
        cur = 100;
        stop = 0;
        flip = 0;
        bus.sendThrottle = 11'd100;
        bus.sendTelemetry = tel;
        bus.sendValid = 1'b1;
        fork
            begin
                while (!stop) begin
                    if (flip) begin
                        cur = cur == 100 ? 200 : 100;
                        bus.sendThrottle = cur[10:0];
                        flip = 0;
                    end
                    if (bus.sendReady === 1'b1) begin
                        q.push_back(model_frame(cur, tel));
                        flip = 1;
                    end
                    @(negedge clk);
                end
            end
            begin
                prev = 0;
                for (int i = 0; i < 4; i++) begin
                    capture(i == 0 ? 10 : 3);
                    exp_f = q.size() != 0 ? q.pop_front() : 16'hxxxx;
                    vectors++; if (w_ok !== 1'b1 || decode() !== exp_f) begin miscompares++; $display("FAIL b2b_frame%0d got %h expected %h", i, decode(), exp_f); end
                    dev = first_dev(exp_f);
                    vectors++; if (dev !== -1) begin miscompares++; $display("FAIL b2b_wave%0d got deviation at %0d expected none", i, dev); end
                    if (i != 0) begin
                        vectors++; if (w_start - prev !== FRAME_T) begin miscompares++; $display("FAIL b2b_period%0d got %0d expected %0d", i, w_start - prev, FRAME_T); end
                    end
                    prev = w_start;
                end
                stop = 1;
            end
        join
        bus.sendValid = 1'b0;
        n = 0;
        while (bus.sendReady !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_repeat();
        int prev, n, act;
        logic tel;
        bit seen;
        tel = 1'($urandom_range(0, 1));
        send(1046, 1'b0);
        autoRepeat = 1'b1;
        capture(10);
        vectors++; if (w_ok !== 1'b1 || decode() !== model_frame(1046, 1'b0)) begin miscompares++; $display("FAIL rep_first got %h expected %h", decode(), model_frame(1046, 1'b0)); end
        prev = w_start;
        fork
            begin
                repeat (500) @(negedge clk);
                bus.sendThrottle = 11'd500;
                bus.sendTelemetry = tel;
                bus.sendValid = 1'b1;
                n = 0;
                while (bus.sendReady !== 1'b1 && n < 3000) begin
                    @(negedge clk);
                    n++;
                end
                @(negedge clk);
                bus.sendValid = 1'b0;
            end
            capture(3);
        join
        vectors++; if (w_ok !== 1'b1 || decode() !== model_frame(1046, 1'b0)) begin miscompares++; $display("FAIL rep_second got %h expected %h", decode(), model_frame(1046, 1'b0)); end
        vectors++; if (w_start - prev !== FRAME_T) begin miscompares++; $display("FAIL rep_period got %0d expected %0d", w_start - prev, FRAME_T); end
        prev = w_start;
        for (int i = 0; i < 2; i++) begin
            capture(3);
            vectors++; if (w_ok !== 1'b1 || decode() !== model_frame(500, tel)) begin miscompares++; $display("FAIL rep_500_%0d got %h expected %h", i, decode(), model_frame(500, tel)); end
            vectors++; if (w_start - prev !== FRAME_T) begin miscompares++; $display("FAIL rep_500_period%0d got %0d expected %0d", i, w_start - prev, FRAME_T); end
            prev = w_start;
        end
        repeat (100) @(negedge clk);
        autoRepeat = 1'b0;
        seen = 0;
        n = 0;
        while (!seen && n < 3000) begin
            @(negedge clk);
            seen = frameDone === 1'b1;
            n++;
        end
        vectors++; if (!seen) begin miscompares++; $display("FAIL rep_drop_done got none expected frameDone"); end
        act = 0;
        repeat (2000) begin
            @(negedge clk);
            if (outPin === ACT) act++;
        end
        vectors++; if (act !== 0) begin miscompares++; $display("FAIL rep_drop_idle got %0d active cycles expected 0", act); end
    endtask

    task automatic test_reset_mid();
        int act, dn, thr;
        logic tel;
        thr = $urandom_range(48, 2047);
        tel = 1'($urandom_range(0, 1));
        autoRepeat = 1'b1;
        send(thr, tel);
        repeat (7 * BIT_T + 15) @(negedge clk);
        resetN = 1'b0;
        @(negedge clk);
        vectors++; if (outPin !== ~ACT) begin miscompares++; $display("FAIL rmid_outPin got %b expected %b", outPin, ~ACT); end
        vectors++; if (busy !== 1'b0 || bus.sendReady !== 1'b1) begin miscompares++; $display("FAIL rmid_state got busy=%b ready=%b expected 0/1", busy, bus.sendReady); end
        resetN = 1'b1;
        act = 0;
        dn = 0;
        repeat (2000) begin
            @(negedge clk);
            if (outPin === ACT) act++;
            if (frameDone === 1'b1) dn++;
        end
        vectors++; if (act !== 0) begin miscompares++; $display("FAIL rmid_norepeat got %0d active cycles expected 0", act); end
        vectors++; if (dn !== 0) begin miscompares++; $display("FAIL rmid_done got %0d pulses expected 0", dn); end
        autoRepeat = 1'b0;
        send(777, 1'b1);
        capture(10);
        vectors++; if (w_ok !== 1'b1 || decode() !== model_frame(777, 1'b1)) begin miscompares++; $display("FAIL rmid_resume got %h expected %h", decode(), model_frame(777, 1'b1)); end
    endtask

    initial begin
        resetN = 1'b0;
        autoRepeat = 1'b0;
        bus.sendValid = 1'b0;
        bus.sendThrottle = '0;
        bus.sendTelemetry = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_patterns();
        test_back_to_back();
        test_repeat();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
